bus_responder: RTL and testbench

BUS_RESPONDER -- requirements
Module: bus_responder

---
 rtl/bus_responder_if.sv | 25 ++
 rtl/bus_responder.sv | 142 ++++++++++++++
 tb/tb_bus_responder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_responder_if.sv
// Request/response handshake bundle between an initiator and the bus responder.
// Each direction has a cycle-valid, payload, tag and acknowledge.
interface bus_responder_if #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13
);
    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
    logic                      bus_respack;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface

// File: rtl/bus_responder.sv
// Memory-backed bus responder: 8-beat line writes, and 8-beat line reads returned
// in ascending order after a fixed wait, with response backpressure.
module bus_responder #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned MEM_WORDS      = 1024,
    parameter int unsigned LATENCY        = 4
) (
    input  logic           clk,
    input  logic           reset,
    bus_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(LATENCY - 1);
    localparam logic [2:0]    LAST_BEAT = 3'd7;
    localparam logic [AW-1:0] LINE_MASK = ~AW'(7);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [2:0]                beat_q, beat_d;
    logic [CW-1:0]             wait_q, wait_d;
    logic [AW-1:0]             base_q, base_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                      resp_cyc_q, resp_cyc_d;
    logic [BUS_DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [BUS_TAG_WIDTH-1:0]  resp_tag_q, resp_tag_d;

    logic                      req_fire;
    logic                      mem_we;
    logic [AW-1:0]             wr_idx;
    logic [AW-1:0]             next_idx;

    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Accept only while listening; held low throughout reset regardless of the initiator.
    assign req_fire = reset & bus.bus_reqcyc & ((state_q == IDLE) || (state_q == WDATA));

    // Base is line-aligned, so the add only ever wraps modulo MEM_WORDS.
    assign wr_idx   = base_q + AW'(beat_q);
    assign next_idx = base_q + AW'(beat_q) + AW'(1);

    assign bus.bus_reqack  = req_fire;
    assign bus.bus_respcyc = resp_cyc_q;
    assign bus.bus_resp    = resp_data_q;
    assign bus.bus_resptag = resp_tag_q;

    // Backing store is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= bus.bus_req;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            wait_q      <= '0;
            base_q      <= '0;
            tag_q       <= '0;
            resp_cyc_q  <= 1'b0;
            resp_data_q <= '0;
            resp_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            base_q      <= base_d;
            tag_q       <= tag_d;
            resp_cyc_q  <= resp_cyc_d;
            resp_data_q <= resp_data_d;
            resp_tag_q  <= resp_tag_d;
        end
    end

    // Next-state and next-output logic; response registers are zeroed outside RESP.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        base_d      = base_q;
        tag_d       = tag_q;
        resp_cyc_d  = resp_cyc_q;
        resp_data_d = resp_data_q;
        resp_tag_d  = resp_tag_q;
        mem_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    base_d  = bus.bus_req[3 +: AW] & LINE_MASK;
                    tag_d   = bus.bus_reqtag;
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = bus.bus_reqtag[BUS_TAG_WIDTH-1] ? WAIT : WDATA;
                end
            end
            WDATA: begin
                if (req_fire) begin
                    mem_we = 1'b1;
                    beat_d = beat_q + 3'd1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d     = RESP;
                    resp_cyc_d  = 1'b1;
                    resp_data_d = mem[base_q];
                    resp_tag_d  = tag_q;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            RESP: begin
                if (bus.bus_respack) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == LAST_BEAT) begin
                        state_d     = IDLE;
                        resp_cyc_d  = 1'b0;
                        resp_data_d = '0;
                        resp_tag_d  = '0;
                    end else begin
                        resp_data_d = mem[next_idx];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: stimulus pushes expected response beats into a
// queue, and an independent monitor checks every presented response beat against it.
module tb_bus_responder;
    localparam int unsigned DW  = 64;
    localparam int unsigned TW  = 13;
    localparam int unsigned MW  = 1024;
    localparam int unsigned LAT = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    bus_responder_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus ();

    bus_responder #(
        .BUS_DATA_WIDTH(DW),
        .BUS_TAG_WIDTH (TW),
        .MEM_WORDS     (MW),
        .LATENCY       (LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [TW-1:0] tag, input logic [31:0] hi, input int idx);
        exp_t e;
        e.data = {hi, 32'(idx)};
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    task automatic push_line(input logic [TW-1:0] tag, input logic [31:0] hi);
        for (int i = 0; i < 8; i++) push_beat(tag, hi, i);
    endtask

    // Called just after a rising edge; returns just after the transfer edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic [TW-1:0] t, input string name);
        bus.bus_reqcyc = 1'b1;
        bus.bus_req    = d;
        bus.bus_reqtag = t;
        @(negedge clk);
        check(name, 64'(bus.bus_reqack), 64'd1);
        tick();
        bus.bus_reqcyc = 1'b0;
    endtask

    task automatic write_burst(input logic [DW-1:0] addr, input logic [31:0] hi, input int nbeats);
        send_beat(addr, 13'h0055, "wr_addr_ack");
        for (int i = 0; i < nbeats; i++) send_beat({hi, 32'(i)}, 13'h0055, "wr_data_ack");
    endtask

    task automatic wait_resp(input string name);
        int n = 0;
        while (!bus.bus_respcyc && n < 50) begin
            tick();
            n++;
        end
        check(name, 64'(bus.bus_respcyc), 64'd1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.bus_respcyc) && n < 200) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        tick();
    endtask

    // Response monitor: compare every presented beat; retire it only when acknowledged.
    always @(negedge clk) begin
        if (bus.bus_respcyc) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_extra: got data %h tag %h expected no beat",
                         bus.bus_resp, bus.bus_resptag);
            end else begin
                if (bus.bus_resp !== exp_q[0].data || bus.bus_resptag !== exp_q[0].tag) begin
                    errors++;
                    $display("FAIL resp_beat: got data %h tag %h expected data %h tag %h",
                             bus.bus_resp, bus.bus_resptag, exp_q[0].data, exp_q[0].tag);
                end
                if (bus.bus_respack) void'(exp_q.pop_front());
            end
        end else if (reset) begin
            checks++;
            if (bus.bus_resp !== '0 || bus.bus_resptag !== '0) begin
                errors++;
                $display("FAIL resp_idle_zero: got data %h tag %h expected 0 0",
                         bus.bus_resp, bus.bus_resptag);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.bus_reqcyc  = 1'b1;
        bus.bus_req     = 64'h1000;
        bus.bus_reqtag  = 13'h1FFF;
        bus.bus_respack = 1'b1;

        // Reset holds everything quiet even with a pending request.
        repeat (3) begin
            @(negedge clk);
            check("rst_reqack", 64'(bus.bus_reqack), 64'd0);
            check("rst_respcyc", 64'(bus.bus_respcyc), 64'd0);
            check("rst_resp", 64'(bus.bus_resp), 64'd0);
            check("rst_resptag", 64'(bus.bus_resptag), 64'd0);
        end
        tick();
        reset = 1'b1;

        // Write 0..7 to line 0x1000 in the first cycle after release, then read it back.
        write_burst(64'h1000, 32'h0, 8);
        push_line(13'h1ABC, 32'h0);
        send_beat(64'h1000, 13'h1ABC, "rd_addr_ack");
        n = 1;
        while (!bus.bus_respcyc && n < 50) begin
            tick();
            n++;
        end
        check("read_latency", 64'(n), 64'(LAT + 1));
        wait_drain("drain_basic");

        // Misaligned address and ignored high bits still hit line base 0x1000, beat 0 first.
        push_line(13'h1028, 32'h0);
        send_beat(64'h1028, 13'h1028, "rd_addr_ack");
        wait_drain("drain_misaligned");
        push_line(13'h1300, 32'h0);
        send_beat(64'hFFFF_FFFF_FFFF_F007, 13'h1300, "rd_addr_ack");
        wait_drain("drain_high_bits");

        // Backpressure on beat 2 for three cycles.
        push_line(13'h1BB0, 32'h0);
        send_beat(64'h1000, 13'h1BB0, "rd_addr_ack");
        wait_resp("bp_start");
        tick();
        tick();
        bus.bus_respack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_cyc", 64'(bus.bus_respcyc), 64'd1);
            check("bp_hold_data", 64'(bus.bus_resp), 64'd2);
            tick();
        end
        bus.bus_respack = 1'b1;
        wait_drain("drain_backpressure");

        // Top-of-memory line must not spill into line 0.
        write_burst(64'h0, 32'hB0B0_B0B0, 8);
        write_burst(64'h1FE0, 32'hA0A0_A0A0, 8);
        push_line(13'h1001, 32'hB0B0_B0B0);
        send_beat(64'h0, 13'h1001, "rd_addr_ack");
        wait_drain("drain_line0");
        push_line(13'h1FE0, 32'hA0A0_A0A0);
        send_beat(64'h1FE0, 13'h1FE0, "rd_addr_ack");
        wait_drain("drain_top_line");

        // Reset mid-write keeps the four beats already written.
        write_burst(64'h0800, 32'hD0D0_D0D0, 8);
        write_burst(64'h0800, 32'hC0C0_C0C0, 4);
        reset = 1'b0;
        #1;
        check("wr_abort_respcyc", 64'(bus.bus_respcyc), 64'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) push_beat(13'h1080, 32'hC0C0_C0C0, i);
        for (int i = 4; i < 8; i++) push_beat(13'h1080, 32'hD0D0_D0D0, i);
        send_beat(64'h0800, 13'h1080, "rd_addr_ack");
        wait_drain("drain_partial_write");

        // Reset during beat 4 of a read, then a clean read right after release.
        push_line(13'h1444, 32'h0);
        send_beat(64'h1000, 13'h1444, "rd_addr_ack");
        wait_resp("rr_start");
        repeat (4) tick();
        reset = 1'b0;
        #1;
        check("rd_abort_respcyc", 64'(bus.bus_respcyc), 64'd0);
        check("rd_abort_resp", 64'(bus.bus_resp), 64'd0);
        check("rd_abort_tag", 64'(bus.bus_resptag), 64'd0);
        exp_q.delete();
        bus.bus_reqcyc = 1'b1;
        bus.bus_req    = 64'h1000;
        bus.bus_reqtag = 13'h1555;
        @(negedge clk);
        check("rd_abort_reqack", 64'(bus.bus_reqack), 64'd0);
        tick();
        reset = 1'b1;
        push_line(13'h1555, 32'h0);
        send_beat(64'h1000, 13'h1555, "rd_addr_ack");
        wait_drain("drain_after_reset");

        // A request held through WAIT and RESP is only acknowledged once IDLE returns.
        push_line(13'h1A01, 32'h0);
        send_beat(64'h1000, 13'h1A01, "rd_addr_ack");
        push_line(13'h1A02, 32'h0);
        bus.bus_reqcyc = 1'b1;
        bus.bus_req    = 64'h1000;
        bus.bus_reqtag = 13'h1A02;
        for (int k = 1; k <= int'(LAT) + 8; k++) begin
            @(negedge clk);
            check("busy_reqack", 64'(bus.bus_reqack), 64'd0);
            tick();
        end
        @(negedge clk);
        check("idle_reqack", 64'(bus.bus_reqack), 64'd1);
        check("idle_respcyc", 64'(bus.bus_respcyc), 64'd0);
        tick();
        bus.bus_reqcyc = 1'b0;
        wait_drain("drain_held_request");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
